// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: source select, load types, FSM states.
`default_nettype none

package wb_pkg;

    localparam logic [1:0] WBSEL_LOAD = 2'b00;
    localparam logic [1:0] WBSEL_ALU  = 2'b01;
    localparam logic [1:0] WBSEL_PC   = 2'b10;
    localparam logic [1:0] WBSEL_CSR  = 2'b11;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_MEM = 2'd1;
    localparam logic [1:0] ST_DRAIN    = 2'd2;

endpackage

`default_nettype wire

// File: rtl/load_align_ext.sv
// Combinational load alignment, sign/zero extension and legality check.
`default_nettype none

module load_align_ext
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN/8)
) (
    input  logic [XLEN-1:0]  rdata,
    input  logic [2:0]       funct3,
    input  logic [OFF_W-1:0] byte_off,
    output logic [XLEN-1:0]  data,
    output logic             illegal
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata >> {byte_off, 3'b000};

    always_comb begin
        data    = '0;
        illegal = 1'b0;
        case (funct3)
            LB:  data = XLEN'($signed(shifted[7:0]));
            LBU: data = XLEN'(shifted[7:0]);
            LH: begin
                data    = XLEN'($signed(shifted[15:0]));
                illegal = byte_off[0];
            end
            LHU: begin
                data    = XLEN'(shifted[15:0]);
                illegal = byte_off[0];
            end
            // On RV32 this is the full word; the cast is then an identity.
            LW: begin
                data    = XLEN'($signed(shifted[31:0]));
                illegal = (byte_off[1:0] != 2'b00);
            end
            LWU: begin
                data    = XLEN'(shifted[31:0]);
                illegal = (XLEN != 64) || (byte_off[1:0] != 2'b00);
            end
            LD: begin
                data    = shifted;
                illegal = (XLEN != 64) || (byte_off != '0);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/writeback_stage_pipe.sv
// Registered writeback stage: source select, variable-latency load completion, flush handling.
`default_nettype none

module writeback_stage_pipe
    import wb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ILEN_BYTES = 4,
    parameter int OFF_W      = $clog2(XLEN/8)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_wbsel,
    input  logic [XLEN-1:0]  in_alu,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_csr,
    input  logic [4:0]       in_rd,
    input  logic             in_rf_we,
    input  logic [2:0]       in_ld_funct3,
    input  logic [OFF_W-1:0] in_byte_off,
    input  logic             flush,
    input  logic             mem_rvalid,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             ld_pending,
    output logic [4:0]       ld_pending_rd,
    output logic             illegal_ld
);

    logic [1:0]       state;
    logic [4:0]       ld_rd;
    logic             ld_we;
    logic [2:0]       ld_f3;
    logic [OFF_W-1:0] ld_off;
    logic [XLEN-1:0]  ld_data;
    logic             ld_illegal;
    logic [XLEN-1:0]  sel_data;
    logic             accept;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid & in_ready & ~flush;

    always_comb begin
        sel_data = in_alu;
        case (in_wbsel)
            WBSEL_PC:  sel_data = in_pc + XLEN'(ILEN_BYTES);
            WBSEL_CSR: sel_data = in_csr;
            default:   sel_data = in_alu;
        endcase
    end

    load_align_ext #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_align (
        .rdata    (mem_rdata),
        .funct3   (ld_f3),
        .byte_off (ld_off),
        .data     (ld_data),
        .illegal  (ld_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            ld_rd         <= '0;
            ld_we         <= 1'b0;
            ld_f3         <= '0;
            ld_off        <= '0;
            rf_we         <= 1'b0;
            rf_waddr      <= '0;
            rf_wdata      <= '0;
            ld_pending    <= 1'b0;
            ld_pending_rd <= '0;
            illegal_ld    <= 1'b0;
        end else begin
            rf_we      <= 1'b0;
            illegal_ld <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (in_wbsel == WBSEL_LOAD) begin
                            state         <= ST_WAIT_MEM;
                            ld_rd         <= in_rd;
                            ld_we         <= in_rf_we;
                            ld_f3         <= in_ld_funct3;
                            ld_off        <= in_byte_off;
                            ld_pending    <= 1'b1;
                            ld_pending_rd <= in_rd;
                        end else begin
                            rf_we    <= in_rf_we & (in_rd != 5'd0);
                            rf_waddr <= in_rd;
                            rf_wdata <= sel_data;
                        end
                    end
                end
                ST_WAIT_MEM: begin
                    if (flush) begin
                        // A response arriving with the flush is consumed here, otherwise DRAIN eats it.
                        state      <= mem_rvalid ? ST_IDLE : ST_DRAIN;
                        ld_pending <= 1'b0;
                    end else if (mem_rvalid) begin
                        state      <= ST_IDLE;
                        ld_pending <= 1'b0;
                        if (ld_illegal) begin
                            illegal_ld <= 1'b1;
                        end else begin
                            rf_we    <= ld_we & (ld_rd != 5'd0);
                            rf_waddr <= ld_rd;
                            rf_wdata <= ld_data;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (mem_rvalid) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage_pipe.sv
// Directed self-checking bench for writeback_stage_pipe (XLEN=32).
`default_nettype none

module tb_writeback_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_wbsel;
    logic [31:0] in_alu, in_pc, in_csr;
    logic [4:0]  in_rd;
    logic        in_rf_we;
    logic [2:0]  in_ld_funct3;
    logic [1:0]  in_byte_off;
    logic        flush;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ld_pending;
    logic [4:0]  ld_pending_rd;
    logic        illegal_ld;

    int checks = 0;
    int errors = 0;

    writeback_stage_pipe #(.XLEN(32), .ILEN_BYTES(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_wbsel      (in_wbsel),
        .in_alu        (in_alu),
        .in_pc         (in_pc),
        .in_csr        (in_csr),
        .in_rd         (in_rd),
        .in_rf_we      (in_rf_we),
        .in_ld_funct3  (in_ld_funct3),
        .in_byte_off   (in_byte_off),
        .flush         (flush),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .ld_pending    (ld_pending),
        .ld_pending_rd (ld_pending_rd),
        .illegal_ld    (illegal_ld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [1:0] sel, input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
        in_valid     = 1'b1;
        in_wbsel     = sel;
        in_rd        = rd;
        in_rf_we     = 1'b1;
        in_ld_funct3 = f3;
        in_byte_off  = off;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_wbsel = 2'b00; in_alu = '0; in_pc = '0; in_csr = '0;
        in_rd = '0; in_rf_we = 1'b0; in_ld_funct3 = '0; in_byte_off = '0;
        flush = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        step(); step();
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_illegal", 64'(illegal_ld), 64'd0);
        chk("rst_pending", 64'(ld_pending), 64'd0);
        chk("rst_pending_rd", 64'(ld_pending_rd), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        step();

        // ALU then back-to-back CSR
        op(2'b01, 5'd5, 3'b000, 2'd0); in_alu = 32'h1234_5678;
        step();
        chk("alu_we", 64'(rf_we), 64'd1);
        chk("alu_waddr", 64'(rf_waddr), 64'd5);
        chk("alu_wdata", 64'(rf_wdata), 64'h1234_5678);
        op(2'b11, 5'd7, 3'b000, 2'd0); in_csr = 32'hCAFE_BABE;
        step();
        chk("csr_we", 64'(rf_we), 64'd1);
        chk("csr_waddr", 64'(rf_waddr), 64'd7);
        chk("csr_wdata", 64'(rf_wdata), 64'hCAFE_BABE);

        // link value wraps
        op(2'b10, 5'd9, 3'b000, 2'd0); in_pc = 32'hFFFF_FFFC;
        step();
        chk("pc_we", 64'(rf_we), 64'd1);
        chk("pc_wdata", 64'(rf_wdata), 64'h0);
        op(2'b10, 5'd9, 3'b000, 2'd0); in_pc = 32'h0000_1000;
        step();
        chk("pc2_wdata", 64'(rf_wdata), 64'h1004);

        // rd=0 suppressed, then bubble
        op(2'b01, 5'd0, 3'b000, 2'd0); in_alu = 32'h0000_0077;
        step();
        chk("rd0_we", 64'(rf_we), 64'd0);
        in_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        chk("idle_rvalid_we", 64'(rf_we), 64'd0);
        mem_rvalid = 1'b0;

        // LB, offset 3, three idle cycles of latency
        op(2'b00, 5'd10, 3'b000, 2'd3);
        step();
        in_valid = 1'b0;
        chk("lb_ready_wait", 64'(in_ready), 64'd0);
        chk("lb_pending", 64'(ld_pending), 64'd1);
        chk("lb_pending_rd", 64'(ld_pending_rd), 64'd10);
        chk("lb_we_wait", 64'(rf_we), 64'd0);
        step(); step();
        chk("lb_pending_gap", 64'(ld_pending), 64'd1);
        chk("lb_ready_gap", 64'(in_ready), 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0000;
        step();
        mem_rvalid = 1'b0;
        chk("lb_we", 64'(rf_we), 64'd1);
        chk("lb_waddr", 64'(rf_waddr), 64'd10);
        chk("lb_wdata", 64'(rf_wdata), 64'hFFFF_FF80);
        chk("lb_pending_clr", 64'(ld_pending), 64'd0);
        chk("lb_ready_after", 64'(in_ready), 64'd1);

        // LH at odd offset is illegal
        op(2'b00, 5'd11, 3'b001, 2'd1);
        step();
        in_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_rvalid = 1'b0;
        chk("lh_odd_illegal", 64'(illegal_ld), 64'd1);
        chk("lh_odd_we", 64'(rf_we), 64'd0);
        chk("lh_odd_ready", 64'(in_ready), 64'd1);
        step();
        chk("lh_odd_pulse_end", 64'(illegal_ld), 64'd0);

        // LHU offset 2, LH offset 2, LW offset 0, LD illegal on RV32
        op(2'b00, 5'd12, 3'b101, 2'd2);
        step();
        in_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h8001_ABCD;
        step();
        mem_rvalid = 1'b0;
        chk("lhu_wdata", 64'(rf_wdata), 64'h0000_8001);
        op(2'b00, 5'd12, 3'b001, 2'd2);
        step();
        in_valid = 1'b0; mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        chk("lh_wdata", 64'(rf_wdata), 64'hFFFF_8001);
        op(2'b00, 5'd13, 3'b010, 2'd0);
        step();
        in_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_rvalid = 1'b0;
        chk("lw_we", 64'(rf_we), 64'd1);
        chk("lw_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
        op(2'b00, 5'd13, 3'b011, 2'd0);
        step();
        in_valid = 1'b0; mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        chk("ld_rv32_illegal", 64'(illegal_ld), 64'd1);
        chk("ld_rv32_we", 64'(rf_we), 64'd0);

        // flush one cycle after accept, response two cycles later
        op(2'b00, 5'd14, 3'b100, 2'd0);
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("drain_ready", 64'(in_ready), 64'd0);
        chk("drain_pending", 64'(ld_pending), 64'd0);
        step();
        chk("drain_ready2", 64'(in_ready), 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_00AA;
        step();
        mem_rvalid = 1'b0;
        chk("drain_we", 64'(rf_we), 64'd0);
        chk("drain_exit_ready", 64'(in_ready), 64'd1);
        op(2'b01, 5'd15, 3'b000, 2'd0); in_alu = 32'h0000_0055;
        step();
        chk("post_drain_we", 64'(rf_we), 64'd1);
        chk("post_drain_wdata", 64'(rf_wdata), 64'h55);

        // flush with same-cycle response in WAIT_MEM
        op(2'b00, 5'd16, 3'b000, 2'd0);
        step();
        in_valid = 1'b0; flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0011;
        step();
        flush = 1'b0; mem_rvalid = 1'b0;
        chk("flush_rv_we", 64'(rf_we), 64'd0);
        chk("flush_rv_ready", 64'(in_ready), 64'd1);
        chk("flush_rv_pending", 64'(ld_pending), 64'd0);

        // flush in IDLE drops the concurrent op
        op(2'b01, 5'd17, 3'b000, 2'd0); in_alu = 32'h0000_0099; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_idle_we", 64'(rf_we), 64'd0);
        chk("flush_idle_wdata", 64'(rf_wdata), 64'h55);

        // reset mid-WAIT_MEM abandons the load
        op(2'b00, 5'd18, 3'b010, 2'd0);
        step();
        in_valid = 1'b0;
        chk("pre_rst_pending", 64'(ld_pending), 64'd1);
        rst_n = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        step();
        mem_rvalid = 1'b0;
        chk("mid_rst_we", 64'(rf_we), 64'd0);
        chk("mid_rst_wdata", 64'(rf_wdata), 64'd0);
        chk("mid_rst_waddr", 64'(rf_waddr), 64'd0);
        chk("mid_rst_pending", 64'(ld_pending), 64'd0);
        chk("mid_rst_pending_rd", 64'(ld_pending_rd), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        step();
        chk("post_rst_we", 64'(rf_we), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
